frame2fifo72: RTL and testbench
===============================

# frame2fifo72

Upstream framer for the 10G transmit path. It accepts user frames as 64-bit beats with byte enables and encodes them into 72-bit XGMII-layout words: start/preamble, data, terminate and inter-frame idle. It writes those words into the TX FIFO, and `fifo72toxgmii` drains that FIFO onto `xgmii_txd`. The word layout is bit `64+i` = control flag for lane `i`, and lane `i` occupies data bits `[8i+7:8i]`.

## Interface
Parameters:
- `IFG_WORDS`, default 1: number of idle words (ctrl 8'hff, data 64'h0707070707070707) written after each terminate; 1..4.

Ports:
- `sys_clk` in 1: single clock for all logic.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `tx_data` in 64: frame beat, lane 0 = first byte.
- `tx_keep` in 8: byte enables, contiguous from bit 0; only honoured on the eof beat.
- `tx_sof` in 1: first beat of frame.
- `tx_eof` in 1: last beat of frame.
- `tx_valid` in 1: beat present.
- `tx_ready` out 1: beat consumed this cycle.
- `din` out 72: FIFO write word.
- `wr_en` out 1: FIFO write strobe.
- `full` in 1: FIFO full.
- `frame_cnt` out 32: frames completed.
- `drop_cnt` out 32: beats discarded.

## Operation
- States:
  - IDLE
  - PRE
  - DATA
  - TERM
  - IFG, with an IFG word counter.
- IDLE:
  - `tx_valid & tx_sof` → PRE; the beat is held (`tx_ready`=0).
  - `tx_valid & !tx_sof` → beat discarded (`tx_ready`=1, drop counted).
- PRE: write 72'h01_D5555555555555FB; → DATA.
- DATA:
  - Beat without eof → write {8'h00, tx_data}.
  - Eof beat with n = count of contiguous ones from `tx_keep[0]`:
    - n<8 → write the merged word: lanes <n data, lane n = FD, lanes >n = 07, ctrl = ~((1<<n)-1); → IFG.
    - n=8 → write {8'h00, tx_data}; → TERM.
- DATA, sof on a non-first beat: write lane0 = FE (error), lanes 1-7 = FD/07 (terminate in lane 1), ctrl 8'hff; the sof beat is **not** consumed; → IFG. The aborted frame is not counted in `frame_cnt`.
- TERM: write 72'hff_07070707070707FD; → IFG.
- IFG: write `IFG_WORDS` idle words; → IDLE.
- Every state transition requires `wr_en`. When `full`=1, `wr_en`=0, `tx_ready`=0 and the state holds.
- The `frame_cnt` increment occurs on entering IFG from a normal terminate. Counters wrap at 2^32.

## Timing
- `din`, `wr_en` and `tx_ready` are combinational from the state register, the `tx_*` inputs and `full`. The write lands on the same edge as the beat acceptance, so latency is 0.
- `tx_ready` is also 0 in PRE, TERM and IFG.
- Minimum overhead per frame: 1 (PRE) + 0/1 (TERM) + `IFG_WORDS` cycles.
- Reset (asynchronous, at any point including mid-frame) → IDLE, IFG counter 0, counters 0, `wr_en`=0, `tx_ready`=0, `din`=0. A partially written frame is left unterminated in the FIFO; downstream must be flushed with it.

## Configuration
- `FRAME2FIFO72_STATS_EN`:
  - Defined: `frame_cnt` and `drop_cnt` are implemented as described.
  - Undefined: no counter flops; both ports are tied to 0. Framing behaviour is identical either way.

## Structure
- Package `xgmii_pkg` holds:
  - Constants `XGMII_IDLE` (8'h07), `XGMII_START` (8'hFB), `XGMII_TERM` (8'hFD), `XGMII_ERROR` (8'hFE), `XGMII_PREAMBLE_WORD`, `XGMII_IDLE_WORD`.
  - The state enum.
- One sub-module, `xgmii_term_merge`: combinational; takes `tx_data` and n and produces the 72-bit terminate-merged word, covering both the n<8 merged word and the n=8 FD word.

## Test plan
- 16-byte frame (2 beats, keep ff), `full`=0 → writes PRE word, two data words with ctrl 00, 72'hff_07070707070707FD, one idle word; `frame_cnt`=1.
- 13-byte frame (eof keep 8'h1f) → last write 72'he0_07_07_FD_xxxxxxxxxx (lanes 0-4 data); no TERM word; 4 writes total.
- `full` asserted for 3 cycles mid-DATA → `wr_en` and `tx_ready` are 0 for those cycles; word sequence unchanged, no duplicates or losses.
- sof on the second beat of a frame → error word 72'hff_0707070707_07FD_FE written, idle written, then the new frame starts with PRE; `frame_cnt` unchanged by the aborted frame.
- Beats with `tx_valid`=1, `tx_sof`=0 in IDLE (×3) → no writes; `drop_cnt`=3.
- `sys_rst_n` pulled low mid-DATA → `wr_en` and `tx_ready` drop immediately; next frame starts cleanly from PRE.

Source files
------------

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control characters, fixed 72-bit words and framer states.
package xgmii_pkg;
  localparam logic [7:0] XGMII_IDLE = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [71:0] XGMII_PREAMBLE_WORD = {8'h01, 8'hD5, {6{8'h55}}, XGMII_START};
  localparam logic [71:0] XGMII_IDLE_WORD = {8'hff, {8{XGMII_IDLE}}};
  // Error in lane 0 and terminate in lane 1 closes an aborted frame.
  localparam logic [71:0] XGMII_ABORT_WORD = {8'hff, {6{XGMII_IDLE}}, XGMII_TERM, XGMII_ERROR};
  typedef enum logic [2:0] {IDLE, PRE, DATA, TERM, IFG} state_t;
endpackage

// File: rtl/xgmii_term_merge.sv
// xgmii_term_merge: builds the terminate word for n valid bytes; n=8 yields the standalone FD word.
module xgmii_term_merge
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  n,
  output logic [71:0] word
);
  logic [2:0] m;
  assign m = n[3] ? 3'd0 : n[2:0];
  always_comb begin
    word = '0;
    for (int i = 0; i < 8; i++) begin
      word[8*i +: 8] = (i < int'(m)) ? data[8*i +: 8] : (i == int'(m)) ? XGMII_TERM : XGMII_IDLE;
      word[64+i] = i >= int'(m);
    end
  end
endmodule

// File: rtl/frame2fifo72.sv
// frame2fifo72: frames 64-bit user beats into 72-bit XGMII-layout TX FIFO words.
// Define FRAME2FIFO72_STATS_EN to implement frame_cnt/drop_cnt; otherwise both read 0.
module frame2fifo72
  import xgmii_pkg::*;
#(
  parameter int IFG_WORDS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] tx_data,
  input  logic [7:0]  tx_keep,
  input  logic        tx_sof,
  input  logic        tx_eof,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [71:0] din,
  output logic        wr_en,
  input  logic        full,
  output logic [31:0] frame_cnt,
  output logic [31:0] drop_cnt
);
  state_t state, nxt;
  logic [1:0] ifg_cnt;
  logic first, abort, last, eof_part;
  logic [3:0] n, mn;
  logic [71:0] merged;
  always_comb begin
    n = 4'd8;
    for (int i = 7; i >= 0; i--) if (!tx_keep[i]) n = 4'(i);
  end
  assign mn = (state == TERM) ? 4'd8 : n;
  assign abort = tx_valid & tx_sof & !first;
  assign last = ifg_cnt == 2'(IFG_WORDS - 1);
  assign eof_part = tx_eof & !n[3];
  xgmii_term_merge u_merge (.data(tx_data), .n(mn), .word(merged));
  // first marks the sof beat held over from IDLE, so only a later sof aborts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      ifg_cnt <= '0;
      first <= 1'b0;
    end else begin
      state <= nxt;
      ifg_cnt <= (state == IFG && wr_en) ? (last ? 2'd0 : ifg_cnt + 2'd1) : ifg_cnt;
      first <= (state == PRE) ? 1'b1 : tx_ready ? 1'b0 : first;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (tx_valid & tx_sof & !full) nxt = PRE;
      PRE: if (!full) nxt = DATA;
      DATA: if (tx_valid & !full) nxt = abort ? IFG : !tx_eof ? DATA : n[3] ? TERM : IFG;
      TERM: if (!full) nxt = IFG;
      IFG: if (!full & last) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    wr_en = sys_rst_n & !full & ((state == PRE) | (state == TERM) | (state == IFG) | ((state == DATA) & tx_valid));
    tx_ready = sys_rst_n & !full & tx_valid & ((state == IDLE) ? !tx_sof : (state == DATA) & !abort);
    din = (state == PRE) ? XGMII_PREAMBLE_WORD :
          (state == TERM) ? merged :
          (state == IFG) ? XGMII_IDLE_WORD :
          (state != DATA) ? '0 :
          abort ? XGMII_ABORT_WORD :
          eof_part ? merged : {8'h00, tx_data};
  end
`ifdef FRAME2FIFO72_STATS_EN
  logic frame_done, drop;
  assign frame_done = wr_en & ((state == TERM) | ((state == DATA) & !abort & eof_part));
  assign drop = tx_ready & (state == IDLE);
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 32'(frame_done);
      drop_cnt <= drop_cnt + 32'(drop);
    end
  end
`else
  assign frame_cnt = '0;
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_frame2fifo72.sv
// tb_frame2fifo72: directed per-scenario checks of frame2fifo72 word sequences and counters.
module tb_frame2fifo72;
`ifdef FRAME2FIFO72_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [71:0] PRE_W = 72'h01_D5555555555555FB;
  localparam logic [71:0] IDL_W = 72'hff_0707070707070707;
  localparam logic [71:0] TRM_W = 72'hff_07070707070707FD;
  localparam logic [71:0] ABT_W = 72'hff_070707070707FDFE;
  localparam logic [63:0] D0 = 64'h0807060504030201;
  localparam logic [63:0] D1 = 64'h100f0e0d0c0b0a09;
  localparam logic [63:0] D2 = 64'h1817161514131211;
  localparam logic [63:0] E0 = 64'h1122334455667788;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] k;
    logic [63:0] d;
    logic [2:0] res;
    logic [71:0] w;
  } vec_t;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [63:0] tx_data = '0;
  logic [7:0] tx_keep = '0;
  logic tx_sof = 1'b0, tx_eof = 1'b0, tx_valid = 1'b0, full = 1'b0;
  logic tx_ready, wr_en;
  logic [71:0] din;
  logic [31:0] frame_cnt, drop_cnt;
  int n_cmp = 0, n_err = 0;
  int exp_frames = 0, exp_drops = 0;
  vec_t vs[$];

  always #5 sys_clk = ~sys_clk;

  frame2fifo72 dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data), .tx_keep(tx_keep),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .din(din), .wr_en(wr_en), .full(full), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // ctl = {valid, sof, eof, full}; res = {wr_en, tx_ready, check din}
  function automatic vec_t mk(logic [3:0] ctl, logic [7:0] k, logic [63:0] d, logic [2:0] res, logic [71:0] w);
    mk = {ctl, k, d, res, w};
  endfunction

  task automatic drive(input vec_t x);
    @(posedge sys_clk);
    #1;
    {tx_valid, tx_sof, tx_eof, full} = x.ctl;
    tx_keep = x.k;
    tx_data = x.d;
    #4;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({wr_en, tx_ready, din} !== 74'h0) begin
      n_err++;
      $display("FAIL reset_outputs: wr_en=%b tx_ready=%b din=%h, want 0 0 0", wr_en, tx_ready, din);
    end
    n_cmp++;
    if ({frame_cnt, drop_cnt} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_counters: frame_cnt=%0d drop_cnt=%0d, want 0 0", frame_cnt, drop_cnt);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_frame16;
    vs = {};
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b111, {8'h00, D0}));
    vs.push_back(mk(4'b1010, 8'hff, D1, 3'b111, {8'h00, D1}));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, TRM_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, IDL_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL frame16[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_frames++;
    n_cmp++;
    if (frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0)) begin
      n_err++;
      $display("FAIL frame16_cnt: frame_cnt=%0d, want %0d", frame_cnt, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_frame13;
    vs = {};
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b111, {8'h00, D0}));
    vs.push_back(mk(4'b1010, 8'h1f, D1, 3'b111, 72'he0_0707FD0D0C0B0A09));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, IDL_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL frame13[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_frames++;
    n_cmp++;
    if (frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0)) begin
      n_err++;
      $display("FAIL frame13_cnt: frame_cnt=%0d, want %0d", frame_cnt, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_full;
    vs = {};
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b111, {8'h00, D0}));
    repeat (3) vs.push_back(mk(4'b1001, 8'hff, D1, 3'b000, 72'h0));
    vs.push_back(mk(4'b1000, 8'hff, D1, 3'b111, {8'h00, D1}));
    vs.push_back(mk(4'b1010, 8'hff, D2, 3'b111, {8'h00, D2}));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, TRM_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, IDL_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL full[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_frames++;
    n_cmp++;
    if (frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0)) begin
      n_err++;
      $display("FAIL full_cnt: frame_cnt=%0d, want %0d", frame_cnt, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_abort;
    vs = {};
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b111, {8'h00, D0}));
    vs.push_back(mk(4'b1110, 8'h01, E0, 3'b101, ABT_W));
    vs.push_back(mk(4'b1110, 8'h01, E0, 3'b101, IDL_W));
    vs.push_back(mk(4'b1110, 8'h01, E0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1110, 8'h01, E0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1110, 8'h01, E0, 3'b111, 72'hfe_070707070707FD88));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, IDL_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL abort[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_frames++;
    n_cmp++;
    if (frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0)) begin
      n_err++;
      $display("FAIL abort_cnt: frame_cnt=%0d, want %0d", frame_cnt, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_drop;
    vs = {};
    repeat (3) vs.push_back(mk(4'b1000, 8'hff, D1, 3'b011, 72'h0));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL drop[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_drops += 3;
    n_cmp++;
    if (drop_cnt !== (STATS ? 32'(exp_drops) : 32'd0) || frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0)) begin
      n_err++;
      $display("FAIL drop_cnt: drop_cnt=%0d frame_cnt=%0d, want %0d %0d", drop_cnt, frame_cnt, STATS ? exp_drops : 0, STATS ? exp_frames : 0);
    end
  endtask

  task automatic test_reset_mid;
    vs = {};
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b001, 72'h0));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b101, PRE_W));
    vs.push_back(mk(4'b1100, 8'hff, D0, 3'b111, {8'h00, D0}));
    vs.push_back(mk(4'b1000, 8'hff, D1, 3'b111, {8'h00, D1}));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL rstmid_pre[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, tx_ready, din} !== 74'h0 || {frame_cnt, drop_cnt} !== 64'h0) begin
      n_err++;
      $display("FAIL rstmid_async: wr_en=%b tx_ready=%b din=%h frame_cnt=%0d drop_cnt=%0d, want all 0", wr_en, tx_ready, din, frame_cnt, drop_cnt);
    end
    #2;
    sys_rst_n = 1'b1;
    exp_frames = 0;
    exp_drops = 0;
    vs = {};
    vs.push_back(mk(4'b1110, 8'hff, D2, 3'b001, 72'h0));
    vs.push_back(mk(4'b1110, 8'hff, D2, 3'b101, PRE_W));
    vs.push_back(mk(4'b1110, 8'hff, D2, 3'b111, {8'h00, D2}));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, TRM_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b101, IDL_W));
    vs.push_back(mk(4'b0000, 8'h00, 64'h0, 3'b001, 72'h0));
    foreach (vs[i]) begin
      drive(vs[i]);
      n_cmp++;
      if ({wr_en, tx_ready} !== vs[i].res[2:1] || (vs[i].res[0] && din !== vs[i].w)) begin
        n_err++;
        $display("FAIL rstmid_post[%0d]: wr_en=%b tx_ready=%b din=%h, want %b %b %h", i, wr_en, tx_ready, din, vs[i].res[2], vs[i].res[1], vs[i].w);
      end
    end
    exp_frames++;
    n_cmp++;
    if (frame_cnt !== (STATS ? 32'(exp_frames) : 32'd0) || drop_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL rstmid_cnt: frame_cnt=%0d drop_cnt=%0d, want %0d 0", frame_cnt, drop_cnt, STATS ? exp_frames : 0);
    end
  endtask

  initial begin
    test_reset;
    test_frame16;
    test_frame13;
    test_full;
    test_abort;
    test_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
